// File: rtl/pmod_adc_responder.sv
// Far end of the PmodADC SAR link: DAC shift/latch, S/H and comparator.
// Define PMOD_ADC_RESP_FRAME_CHECK_EN to build the frame-length checker.
module pmod_adc_responder #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ADC_SH_i,
  input  logic              ADC_Ser_i,
  input  logic              ADC_SClk_i,
  input  logic              ADC_LClk_i,
  output logic              ADC_Comp_o,
  input  logic [DATA_W-1:0] analog_val_i,
  output logic [DATA_W-1:0] sample_o,
  output logic [DATA_W-1:0] dac_code_o,
  output logic [15:0]       frame_cnt_o,
  output logic              frame_err_o
);

  // Pin order: 0 SH, 1 Ser, 2 SClk, 3 LClk
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]        hist_q, hist_d;
  logic [3:0]        pins, sync_out;
  logic              sclk_rise, lclk_rise;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              comp_q, comp_d;

  assign pins     = {ADC_LClk_i, ADC_SClk_i, ADC_Ser_i, ADC_SH_i};
  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pins};
    hist_d      = sync_out;
    sclk_rise   = sync_out[2] & ~hist_q[2];
    lclk_rise   = sync_out[3] & ~hist_q[3];
    shreg_d     = shreg_q;
    dac_d       = dac_q;
    frame_cnt_d = frame_cnt_q;
    sample_d    = sample_q;
    comp_d      = (dac_q <= sample_q);
    if (sclk_rise)
      shreg_d = {sync_out[1], shreg_q[DATA_W-1:1]};
    // Latch sees the pre-shift register on a coincident SClk rise
    if (lclk_rise) begin
      dac_d       = shreg_q;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (sync_out[0])
      sample_d = analog_val_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q      <= '0;
      hist_q      <= '0;
      shreg_q     <= '0;
      dac_q       <= '0;
      sample_q    <= '0;
      frame_cnt_q <= '0;
      comp_q      <= 1'b1;
    end else begin
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      shreg_q     <= shreg_d;
      dac_q       <= dac_d;
      sample_q    <= sample_d;
      frame_cnt_q <= frame_cnt_d;
      comp_q      <= comp_d;
    end
  end

  assign dac_code_o  = dac_q;
  assign sample_o    = sample_q;
  assign frame_cnt_o = frame_cnt_q;
  assign ADC_Comp_o  = comp_q;

`ifdef PMOD_ADC_RESP_FRAME_CHECK_EN
  localparam int CNT_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    frame_err_d = lclk_rise & (bit_cnt_q != CNT_FULL);
    // A coincident shift belongs to the next frame
    if (lclk_rise)
      bit_cnt_d = sclk_rise ? CNT_W'(1) : '0;
    else if (sclk_rise && bit_cnt_q != CNT_MAX)
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bit_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err_o = frame_err_q;
`else
  assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pmod_adc_responder.sv
// Directed bench for pmod_adc_responder.
// Expects a frame_err pulse only when PMOD_ADC_RESP_FRAME_CHECK_EN is set.
module tb_pmod_adc_responder;

  localparam int DW = 16;
  localparam int SS = 2;

`ifdef PMOD_ADC_RESP_FRAME_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          sh = 1'b0;
  logic          ser = 1'b0;
  logic          sclk = 1'b0;
  logic          lclk = 1'b0;
  logic          comp;
  logic [DW-1:0] analog = '0;
  logic [DW-1:0] sample;
  logic [DW-1:0] dac;
  logic [15:0]   fcnt;
  logic          ferr;

  int errors = 0;
  int checks = 0;
  int err_cyc = 0;

  pmod_adc_responder #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .ADC_SH_i     (sh),
    .ADC_Ser_i    (ser),
    .ADC_SClk_i   (sclk),
    .ADC_LClk_i   (lclk),
    .ADC_Comp_o   (comp),
    .analog_val_i (analog),
    .sample_o     (sample),
    .dac_code_o   (dac),
    .frame_cnt_o  (fcnt),
    .frame_err_o  (ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (ferr) err_cyc++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
    tick(1);
    err_cyc = 0;
  endtask

  task automatic shift_bit(input logic b);
    ser = b;
    tick(1);
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
    tick(4);
  endtask

  task automatic send(input logic [DW-1:0] v, input int n);
    for (int i = 0; i < n; i++) shift_bit(v[i]);
  endtask

  task automatic latch();
    lclk = 1'b1;
    tick(4);
    lclk = 1'b0;
    tick(4);
  endtask

  initial begin
    tick(3);
    do_reset();
    check("rst_dac", 32'(dac), 32'h0);
    check("rst_sample", 32'(sample), 32'h0);
    check("rst_comp", 32'(comp), 32'h1);
    check("rst_fcnt", 32'(fcnt), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);

    analog = 16'h2FFF;
    sh = 1'b1;
    tick(5);
    sh = 1'b0;
    tick(5);
    analog = 16'h0000;
    tick(5);
    check("t2_hold", 32'(sample), 32'h2FFF);
    send(16'h2FFF, 16);
    latch();
    check("t2_dac", 32'(dac), 32'h2FFF);
    check("t2_comp", 32'(comp), 32'h1);
    check("t2_fcnt", 32'(fcnt), 32'h1);
    check("t2_ferr", 32'(err_cyc), 32'h0);

    send(16'h3000, 16);
    lclk = 1'b1;
    tick(SS);
    check("t3_dac_pre", 32'(dac), 32'h2FFF);
    check("t3_comp_pre", 32'(comp), 32'h1);
    tick(1);
    check("t3_dac_edge", 32'(dac), 32'h3000);
    check("t3_comp_lag", 32'(comp), 32'h1);
    tick(1);
    check("t3_comp_new", 32'(comp), 32'h0);
    tick(1);
    lclk = 1'b0;
    tick(4);
    check("t3_fcnt", 32'(fcnt), 32'h2);

    err_cyc = 0;
    send(16'h0ABC, 15);
    latch();
    check("t4_dac", 32'(dac), 32'h1578);
    check("t4_ferr", 32'(err_cyc), 32'(ERR_EXP));
    check("t4_fcnt", 32'(fcnt), 32'h3);
    check("t4_comp", 32'(comp), 32'h1);

    do_reset();
    send(16'h1234, 15);
    ser = 1'b0;
    tick(1);
    sclk = 1'b1;
    lclk = 1'b1;
    tick(4);
    sclk = 1'b0;
    lclk = 1'b0;
    tick(4);
    check("t5_dac", 32'(dac), 32'h2468);
    check("t5_ferr", 32'(err_cyc), 32'(ERR_EXP));
    err_cyc = 0;
    send(16'hFFFF, 15);
    latch();
    check("t5_next_dac", 32'(dac), 32'hFFFE);
    check("t5_next_ferr", 32'(err_cyc), 32'h0);
    check("t5_fcnt", 32'(fcnt), 32'h2);

    send(16'h00FF, 8);
    do_reset();
    check("t6_rst_fcnt", 32'(fcnt), 32'h0);
    send(16'hA5A5, 16);
    latch();
    check("t6_dac", 32'(dac), 32'hA5A5);
    check("t6_fcnt", 32'(fcnt), 32'h1);
    check("t6_ferr", 32'(err_cyc), 32'h0);
    check("t6_comp", 32'(comp), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
